// File: rtl/gauss_row_sequencer_pkg.sv
// Shared types and defaults for the Gaussian filter row sequencer.
package gauss_row_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRow   = 2'd1;
    localparam state_t StGap   = 2'd2;
    localparam state_t StDrain = 2'd3;

    localparam int unsigned DefWidth       = 640;
    localparam int unsigned DefHeight      = 512;
    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned DefGapCycles   = 100;
    localparam int unsigned DefMaxInflight = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gauss_row_sequencer_if.sv
// AXI-Stream style handshake bundle used for the source, filter input and filter monitor sides.
interface gauss_row_sequencer_if
    import gauss_row_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave (input tdata, input tvalid, input tlast, output tready);
    modport monitor (input tvalid, input tready, input tlast);
endinterface

// File: rtl/gauss_row_sequencer_gap_timer.sv
// Loadable down-counter for the inter-row blanking gap; saturates at zero.
module gauss_row_sequencer_gap_timer #(
    parameter int unsigned Width = 7
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             hold,
    output logic             zero
);
    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/gauss_row_sequencer.sv
// Gates a raw pixel stream into gauss_filter_1x5 row by row, with blanking gaps and a
// limit on rows in flight inside the filter.
module gauss_row_sequencer
    import gauss_row_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH        = DefWidth,
    parameter int unsigned HEIGHT       = DefHeight,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned GAP_CYCLES   = DefGapCycles,
    parameter int unsigned MAX_INFLIGHT = DefMaxInflight
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_len_o,
    input  logic                                 err_clr_i,
    output logic [cnt_width(HEIGHT + 1)-1:0]     row_cnt_o,
    gauss_row_sequencer_if.slave                 src,
    gauss_row_sequencer_if.master                flt,
    gauss_row_sequencer_if.monitor               mon
);
    localparam int unsigned ColW = cnt_width(WIDTH);
    localparam int unsigned RowW = cnt_width(HEIGHT + 1);
    localparam int unsigned GapW = cnt_width(GAP_CYCLES);
    localparam int unsigned InfW = cnt_width(MAX_INFLIGHT + 1);

    state_t          state_q, state_d;
    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    logic [InfW-1:0] inflight_q;
    logic            err_q;
    logic            done_q;

    logic            in_row, col_last, flt_last, beat, row_end, mon_end;
    logic            len_bad, gap_zero, room, drained, accept;
    logic [DATA_WIDTH-1:0] pix;

    assign in_row   = (state_q == StRow);
    assign col_last = (col_q == ColW'(WIDTH - 1));
    assign flt_last = in_row & (col_last | src.tlast);
    assign beat     = in_row & src.tvalid & flt.tready;
    assign row_end  = beat & flt_last;
    assign mon_end  = mon.tvalid & mon.tready & mon.tlast;
    assign room     = (inflight_q < InfW'(MAX_INFLIGHT));
    assign drained  = (inflight_q == '0);
    assign accept   = (state_q == StIdle) & start_i;
    // Row closes on whichever comes first; a disagreement with the source marker is an error.
    assign len_bad  = row_end & (col_last != src.tlast);

    assign pix        = src.tdata;
    assign flt.tdata  = pix;
    assign flt.tvalid = src.tvalid & in_row;
    assign flt.tlast  = flt_last;
    assign flt.tuser  = in_row & (row_q == '0) & (col_q == '0);
    assign src.tready = flt.tready & in_row;

    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign err_len_o = err_q;
    assign row_cnt_o = row_q;

    gauss_row_sequencer_gap_timer #(
        .Width (GapW)
    ) u_gap_timer (
        .clk      (clk),
        .rst_i    (rst_i),
        .load     (row_end),
        .load_val (GapW'(GAP_CYCLES - 1)),
        .hold     (state_q != StGap),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = StRow;
            StRow:   if (row_end) state_d = StGap;
            StGap: begin
                if (gap_zero) begin
                    if (row_q == RowW'(HEIGHT)) begin
                        state_d = StDrain;
                    end else if (room) begin
                        state_d = StRow;
                    end
                end
            end
            StDrain: if (drained) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StDrain) & drained;

            if (accept) begin
                col_q <= '0;
                row_q <= '0;
            end else if (beat) begin
                col_q <= row_end ? '0 : col_q + ColW'(1);
                if (row_end) row_q <= row_q + RowW'(1);
            end

            // Simultaneous row entry and exit cancel; exit alone floors at zero.
            if (row_end && !mon_end) begin
                inflight_q <= inflight_q + InfW'(1);
            end else if (!row_end && mon_end && !drained) begin
                inflight_q <= inflight_q - InfW'(1);
            end

            if (len_bad) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gauss_row_sequencer.sv
// Directed/random bench for gauss_row_sequencer against a cycle-level behavioural model.
module tb_gauss_row_sequencer;
    localparam int W    = 8;
    localparam int H    = 3;
    localparam int GAP  = 4;
    localparam int MAXI = 2;
    localparam int DW   = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy, done, err;
    logic [1:0] row_cnt;

    gauss_row_sequencer_if #(.DATA_WIDTH(DW)) src_if ();
    gauss_row_sequencer_if #(.DATA_WIDTH(DW)) flt_if ();
    gauss_row_sequencer_if #(.DATA_WIDTH(DW)) mon_if ();

    gauss_row_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .DATA_WIDTH   (DW),
        .GAP_CYCLES   (GAP),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .err_len_o (err),
        .err_clr_i (err_clr),
        .row_cnt_o (row_cnt),
        .src       (src_if),
        .flt       (flt_if),
        .mon       (mon_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: row/blanking bookkeeping and filter occupancy.
    bit m_busy, m_in_row, m_err, m_done;
    int m_col, m_rows, m_gap_left, m_inflight;
    int cyc = 0;
    int echo_q[$];
    int echo_delay = 3;
    bit rnd_mode, inject, force_mon;

    int beats, tuser_cnt, tuser_beat, lo_run, done_cnt;
    int tlast_pos[$];
    int gaps[$];
    int t4_exp[3] = '{7, 13, 21};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_in_row = 0; m_err = 0; m_done = 0;
        m_col = 0; m_rows = 0; m_gap_left = 0; m_inflight = 0;
        echo_q.delete();
    endtask

    task automatic drive();
        bit early;
        early = inject && m_in_row && m_rows == 1 && m_col == 5;
        src_if.tvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        flt_if.tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        src_if.tdata  = DW'($urandom);
        src_if.tlast  = early || (m_col == W - 1);
        err_clr       = early; // collides with the error it causes
    endtask

    task automatic tick();
        bit beat, exp_last, mon_hs, bad, start_c, clr_c;
        int old_inf;
        mon_if.tvalid = force_mon || (echo_q.size() > 0 && echo_q[0] <= cyc);
        mon_if.tlast  = mon_if.tvalid;
        mon_if.tready = force_mon ? 1'b1 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        @(negedge clk);
        exp_last = m_in_row && (m_col == W - 1 || src_if.tlast);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err_len", 32'(err), 32'(m_err));
        chk("row_cnt", 32'(row_cnt), 32'(m_rows));
        chk("src_tready", 32'(src_if.tready), 32'(m_in_row && flt_if.tready));
        chk("flt_tvalid", 32'(flt_if.tvalid), 32'(m_in_row && src_if.tvalid));
        chk("flt_tlast", 32'(flt_if.tlast), 32'(exp_last));
        chk("flt_tuser", 32'(flt_if.tuser), 32'(m_in_row && m_rows == 0 && m_col == 0));
        chk("flt_tdata", 32'(flt_if.tdata), 32'(src_if.tdata));
        if (done) done_cnt++;
        if (flt_if.tvalid && flt_if.tready) begin
            if (flt_if.tlast) tlast_pos.push_back(beats);
            if (flt_if.tuser) begin tuser_cnt++; tuser_beat = beats; end
            beats++;
        end
        if (m_busy && !src_if.tready) lo_run++;
        else if (src_if.tready && lo_run > 0) begin gaps.push_back(lo_run); lo_run = 0; end
        beat    = m_in_row && src_if.tvalid && flt_if.tready;
        mon_hs  = mon_if.tvalid && mon_if.tready && mon_if.tlast;
        bad     = beat && exp_last && ((m_col == W - 1) != src_if.tlast);
        start_c = start;
        clr_c   = err_clr;
        @(posedge clk);
        #1;
        old_inf = m_inflight;
        if (beat && exp_last && !mon_hs) m_inflight++;
        else if (mon_hs && !(beat && exp_last) && m_inflight > 0) m_inflight--;
        m_done = 0;
        if (!m_busy) begin
            if (start_c) begin m_busy = 1; m_in_row = 1; m_rows = 0; m_col = 0; end
        end else if (m_in_row) begin
            if (beat && exp_last) begin
                m_in_row = 0; m_rows++; m_col = 0; m_gap_left = GAP;
            end else if (beat) m_col++;
        end else if (m_gap_left > 1) m_gap_left--;
        else if (m_rows < H) begin
            if (old_inf < MAXI) m_in_row = 1;
        end else if (m_gap_left == 1) m_gap_left = 0;
        else if (old_inf == 0) begin m_busy = 0; m_done = 1; end
        if (bad) m_err = 1;
        else if (clr_c) m_err = 0;
        if (mon_hs && echo_q.size() > 0) void'(echo_q.pop_front());
        if (beat && exp_last) echo_q.push_back(cyc + echo_delay);
        cyc++;
    endtask

    task automatic frame_setup(input bit rnd, input int delay, input bit inj);
        rnd_mode = rnd; echo_delay = delay; inject = inj;
        beats = 0; tuser_cnt = 0; tuser_beat = -1; lo_run = 0; done_cnt = 0;
        tlast_pos.delete(); gaps.delete();
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input bit rnd, input int delay, input bit inj);
        int n = 0;
        frame_setup(rnd, delay, inj);
        while (m_busy && n < 2000) begin
            drive();
            start = rnd && ($urandom_range(0, 7) == 0);
            tick();
            n++;
        end
        start = 1'b0;
        chk("frame_in_budget", 32'(n < 2000), 32'd1);
        drive();
        tick();
        tick();
        chk("done_once", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int n;
        src_if.tdata = '0; src_if.tvalid = 1'b0; src_if.tlast = 1'b0; src_if.tuser = 1'b0;
        flt_if.tready = 1'b0;
        mon_if.tdata = '0; mon_if.tvalid = 1'b0; mon_if.tlast = 1'b0; mon_if.tuser = 1'b0;
        mon_if.tready = 1'b0;
        model_reset();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_row_cnt", 32'(row_cnt), 32'd0);
        chk("rst_flt_tvalid", 32'(flt_if.tvalid), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame: beat count, end-of-row positions, start-of-frame flag, gap length.
        run_frame(1'b0, 3, 1'b0);
        chk("t1_beats", 32'(beats), 32'(W * H));
        chk("t1_tlast_n", 32'(tlast_pos.size()), 32'(H));
        foreach (tlast_pos[i]) chk("t1_tlast_pos", 32'(tlast_pos[i]), 32'(W * i + W - 1));
        chk("t1_tuser_n", 32'(tuser_cnt), 32'd1);
        chk("t1_tuser_beat", 32'(tuser_beat), 32'd0);
        chk("t2_gap_n", 32'(gaps.size()), 32'(H - 1));
        foreach (gaps[i]) chk("t2_gap_len", 32'(gaps[i]), 32'(GAP));
        chk("row_cnt_hold", 32'(row_cnt), 32'(H));

        // Filter tlast while idle must not disturb the occupancy count.
        force_mon = 1'b1;
        tick();
        force_mon = 1'b0;

        // Slow filter: the third row has to wait for the first to leave.
        run_frame(1'b0, 20, 1'b0);
        chk("t3_beats", 32'(beats), 32'(W * H));
        chk("t3_stall", 32'(gaps.size() == 2 && gaps[1] > GAP), 32'd1);

        // Short row from the source.
        run_frame(1'b0, 3, 1'b1);
        chk("t4_beats", 32'(beats), 32'(W * H - 2));
        chk("t4_tlast_n", 32'(tlast_pos.size()), 32'(H));
        foreach (tlast_pos[i]) chk("t4_tlast_pos", 32'(tlast_pos[i]), 32'(t4_exp[i]));
        chk("t4_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("t4_err_clr", 32'(err), 32'd0);

        // Random back-pressure, source gaps and filter latency.
        for (int k = 0; k < 3; k++) begin
            run_frame(1'b1, int'($urandom_range(1, 25)), 1'b0);
            chk("t5_beats", 32'(beats), 32'(W * H));
            chk("t5_tlast_n", 32'(tlast_pos.size()), 32'(H));
        end

        // Asynchronous reset in the middle of the third row.
        frame_setup(1'b0, 3, 1'b0);
        n = 0;
        while (!(m_in_row && m_rows == 2 && m_col == 3) && n < 500) begin
            drive();
            tick();
            n++;
        end
        chk("t6_reached_row2", 32'(n < 500), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_row_cnt", 32'(row_cnt), 32'd0);
        chk("t6_src_tready", 32'(src_if.tready), 32'd0);
        chk("t6_flt_tvalid", 32'(flt_if.tvalid), 32'd0);
        chk("t6_flt_tlast", 32'(flt_if.tlast), 32'd0);
        chk("t6_flt_tuser", 32'(flt_if.tuser), 32'd0);
        model_reset();
        #3 rst_i = 1'b1;
        @(posedge clk);
        #1;
        tick();
        run_frame(1'b0, 3, 1'b0);
        chk("t6_clean_beats", 32'(beats), 32'(W * H));
        chk("t6_clean_tuser", 32'(tuser_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
